// File: rtl/eu_dispatch.sv
// eu_dispatch: dispatch-side driver for the per-EU issue queues.
//
// Takes one renamed instruction per cycle and writes it into exactly one of NUM_EU issue
// queues. Per-queue credit counters track occupancy (including the write in flight), so a
// queue is never written when full. Eligible EUs are selected round-robin; write strobes and
// payload are registered.
//
// Optional feature: define EU_DISPATCH_STALL_CNT_EN to add the stall_cycles_o port and a
// 32-bit counter of cycles in which a valid instruction was presented but not accepted.
//
// Ports:
//   clk             clock, rising edge
//   reset_n         synchronous active-low reset
//   instr_i         instruction payload from rename
//   instr_eu_mask_i bit i set: EU i may execute the instruction
//   instr_valid_i   instr_i / instr_eu_mask_i valid
//   instr_ready_o   instruction accepted when valid & ready
//   iq_instr_o      registered payload, broadcast to all queues
//   iq_valid_o      registered write strobe per queue, one-hot or zero
//   iq_full_i       full flag from each queue
//   iq_pop_i        one-cycle pulse when a queue's consumer takes an entry
//   stall_cycles_o  stall cycle count (EU_DISPATCH_STALL_CNT_EN only)

package pkg_dtypes;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [5:0]  rob_id;
   } type_iqueue_entry;
endpackage

module eu_dispatch
   import pkg_dtypes::*;
#(
   parameter int unsigned NUM_EU            = 4,
   parameter int unsigned LOG2_QUEUE_LENGTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  type_iqueue_entry      instr_i,
   input  logic [NUM_EU-1:0]     instr_eu_mask_i,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   output type_iqueue_entry      iq_instr_o,
   output logic [NUM_EU-1:0]     iq_valid_o,
   input  logic [NUM_EU-1:0]     iq_full_i,
   input  logic [NUM_EU-1:0]     iq_pop_i
`ifdef EU_DISPATCH_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cycles_o
`endif
);

   localparam int unsigned DEPTH = 2 ** LOG2_QUEUE_LENGTH;
   localparam int unsigned CW    = LOG2_QUEUE_LENGTH + 1;
   localparam int unsigned PW    = $clog2(NUM_EU);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]     cnt [NUM_EU];
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     rr_next;
   logic [PW-1:0]     grant_idx;
   logic [NUM_EU-1:0] elig;
   logic [NUM_EU-1:0] grant;
   logic [NUM_EU-1:0] grant_acc;
   logic              found;
   logic              mask_zero;
   logic              accept;

   // A queue is eligible if the instruction may go there and a credit is free.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_EU; i++) begin
         elig[i] = instr_eu_mask_i[i] & (cnt[i] < DEPTH_C) & ~iq_full_i[i];
      end
   end

   // First eligible queue at or after rr_ptr, with wrap-around.
   always_comb begin
      logic [PW-1:0] idx;
      grant     = '0;
      grant_idx = rr_ptr;
      found     = 1'b0;
      idx       = rr_ptr;
      for (int unsigned k = 0; k < NUM_EU; k++) begin
         idx = PW'((32'(rr_ptr) + k) % NUM_EU);
         if (!found && elig[idx]) begin
            found     = 1'b1;
            grant_idx = idx;
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign rr_next   = PW'((32'(grant_idx) + 32'd1) % NUM_EU);
   assign mask_zero = (instr_eu_mask_i == '0);

   // A zero mask is accepted and dropped so it cannot block the stream.
   assign instr_ready_o = reset_n & ((|elig) | mask_zero);
   assign accept        = instr_valid_i & instr_ready_o;
   assign grant_acc     = accept ? grant : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         iq_valid_o <= '0;
         iq_instr_o <= '0;
         for (int i = 0; i < NUM_EU; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         iq_valid_o <= grant_acc;
         if (|grant_acc) begin
            iq_instr_o <= instr_i;
            rr_ptr     <= rr_next;
         end
         // Credit is taken in the accept cycle so the in-flight write is always counted.
         for (int i = 0; i < NUM_EU; i++) begin
            if (grant_acc[i] && !iq_pop_i[i]) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (!grant_acc[i] && iq_pop_i[i] && (cnt[i] != '0)) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   // A pop from a queue holding no credits means the queues and this block disagree.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < NUM_EU; i++) begin
            assert (!(iq_pop_i[i] && (cnt[i] == '0)))
               else $error("eu_dispatch: pop from empty queue %0d", i);
         end
      end
   end

`ifdef EU_DISPATCH_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cycles_o <= '0;
      end else if (instr_valid_i && !instr_ready_o) begin
         stall_cycles_o <= stall_cycles_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_eu_dispatch.sv
// Directed self-checking bench for eu_dispatch (NUM_EU=4, LOG2_QUEUE_LENGTH=2, DEPTH=4).
module tb_eu_dispatch;
   import pkg_dtypes::*;

   logic             clk = 1'b0;
   logic             reset_n;
   type_iqueue_entry instr;
   logic [3:0]       mask;
   logic             valid;
   logic             ready;
   type_iqueue_entry iq_instr;
   logic [3:0]       iq_valid;
   logic [3:0]       iq_full;
   logic [3:0]       iq_pop;
`ifdef EU_DISPATCH_STALL_CNT_EN
   logic [31:0]      stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   eu_dispatch #(
      .NUM_EU           (4),
      .LOG2_QUEUE_LENGTH(2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .instr_i        (instr),
      .instr_eu_mask_i(mask),
      .instr_valid_i  (valid),
      .instr_ready_o  (ready),
      .iq_instr_o     (iq_instr),
      .iq_valid_o     (iq_valid),
      .iq_full_i      (iq_full),
      .iq_pop_i       (iq_pop)
`ifdef EU_DISPATCH_STALL_CNT_EN
      ,
      .stall_cycles_o (stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic type_iqueue_entry mk(input int unsigned k);
      type_iqueue_entry e;
      e.pc     = 32'h0000_1000 + (k << 2);
      e.imm    = 32'hA5A5_0000 ^ k;
      e.rob_id = 6'(k);
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      valid   = 1'b1;
      mask    = 4'b1111;
      instr   = mk(99);
      iq_full = 4'b0000;
      iq_pop  = 4'b0000;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0", ready);
      end
      cyc();
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_iq_valid: got %b expected 0000", iq_valid);
      end
      n_checks++;
      if (iq_instr !== type_iqueue_entry'(0)) begin
         n_fail++;
         $display("FAIL reset_iq_instr: got %h expected 0", iq_instr);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut.cnt[i] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt[%0d]: got %0d expected 0", i, dut.cnt[i]);
         end
      end
      n_checks++;
      if (dut.rr_ptr !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr);
      end
`ifdef EU_DISPATCH_STALL_CNT_EN
      n_checks++;
      if (stall !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_stall: got %0d expected 0", stall);
      end
`endif
      valid   = 1'b0;
      mask    = 4'b0000;
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_round_robin();
      logic [3:0] one;
      logic [3:0] exp;
      one = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         instr = mk(k);
         mask  = 4'b1111;
         valid = 1'b1;
         #1;
         n_checks++;
         if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_ready[%0d]: got %b expected 1", k, ready);
         end
         cyc();
         exp = one << (k % 4);
         n_checks++;
         if (iq_valid !== exp) begin
            n_fail++;
            $display("FAIL rr_strobe[%0d]: got %b expected %b", k, iq_valid, exp);
         end
         n_checks++;
         if (iq_instr !== mk(k)) begin
            n_fail++;
            $display("FAIL rr_payload[%0d]: got %h expected %h", k, iq_instr, mk(k));
         end
      end
      valid = 1'b0;
      mask  = 4'b0000;
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL rr_idle_strobe: got %b expected 0000", iq_valid);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut.cnt[i] !== 3'd2) begin
            n_fail++;
            $display("FAIL rr_cnt[%0d]: got %0d expected 2", i, dut.cnt[i]);
         end
      end
      iq_pop = 4'b1111;
      cyc();
      cyc();
      iq_pop = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut.cnt[i] !== 3'd0) begin
            n_fail++;
            $display("FAIL rr_drain_cnt[%0d]: got %0d expected 0", i, dut.cnt[i]);
         end
      end
   endtask

   task automatic test_credit_exhaustion();
      logic       exp_r;
      logic [3:0] exp_v;
      mask  = 4'b0001;
      valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         instr = mk(20 + ((k < 4) ? k : 4));
         exp_r = (k < 4);
         exp_v = (k < 4) ? 4'b0001 : 4'b0000;
         #1;
         n_checks++;
         if (ready !== exp_r) begin
            n_fail++;
            $display("FAIL credit_ready[%0d]: got %b expected %b", k, ready, exp_r);
         end
         cyc();
         n_checks++;
         if (iq_valid !== exp_v) begin
            n_fail++;
            $display("FAIL credit_strobe[%0d]: got %b expected %b", k, iq_valid, exp_v);
         end
      end
      n_checks++;
      if (dut.cnt[0] !== 3'd4) begin
         n_fail++;
         $display("FAIL credit_full_cnt: got %0d expected 4", dut.cnt[0]);
      end
      iq_pop = 4'b0001;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL credit_pop_cycle_ready: got %b expected 0", ready);
      end
      cyc();
      iq_pop = 4'b0000;
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL credit_after_pop_ready: got %b expected 1", ready);
      end
      n_checks++;
      if (dut.cnt[0] !== 3'd3) begin
         n_fail++;
         $display("FAIL credit_after_pop_cnt: got %0d expected 3", dut.cnt[0]);
      end
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0001) begin
         n_fail++;
         $display("FAIL credit_refill_strobe: got %b expected 0001", iq_valid);
      end
      n_checks++;
      if (iq_instr !== mk(24)) begin
         n_fail++;
         $display("FAIL credit_refill_payload: got %h expected %h", iq_instr, mk(24));
      end
      valid = 1'b0;
      mask  = 4'b0000;
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL credit_single_accept: got %b expected 0000", iq_valid);
      end
      n_checks++;
      if (dut.cnt[0] !== 3'd4) begin
         n_fail++;
         $display("FAIL credit_refull_cnt: got %0d expected 4", dut.cnt[0]);
      end
      iq_pop = 4'b0001;
      repeat (4) cyc();
      iq_pop = 4'b0000;
   endtask

   task automatic test_pop_grant();
      mask  = 4'b0010;
      valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         instr = mk(40 + k);
         cyc();
      end
      n_checks++;
      if (dut.cnt[1] !== 3'd3) begin
         n_fail++;
         $display("FAIL popgrant_pre_cnt: got %0d expected 3", dut.cnt[1]);
      end
      instr  = mk(43);
      iq_pop = 4'b0010;
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL popgrant_ready: got %b expected 1", ready);
      end
      cyc();
      valid  = 1'b0;
      mask   = 4'b0000;
      iq_pop = 4'b0000;
      n_checks++;
      if (dut.cnt[1] !== 3'd3) begin
         n_fail++;
         $display("FAIL popgrant_cnt: got %0d expected 3", dut.cnt[1]);
      end
      n_checks++;
      if (iq_valid !== 4'b0010) begin
         n_fail++;
         $display("FAIL popgrant_strobe: got %b expected 0010", iq_valid);
      end
      n_checks++;
      if (iq_instr !== mk(43)) begin
         n_fail++;
         $display("FAIL popgrant_payload: got %h expected %h", iq_instr, mk(43));
      end
      iq_pop = 4'b0010;
      repeat (3) cyc();
      iq_pop = 4'b0000;
   endtask

   task automatic test_mask_handling();
      instr = mk(50);
      mask  = 4'b0000;
      valid = 1'b1;
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mask0_ready: got %b expected 1", ready);
      end
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL mask0_strobe: got %b expected 0000", iq_valid);
      end
      n_checks++;
      if (dut.rr_ptr !== 2'd2) begin
         n_fail++;
         $display("FAIL mask0_rr_ptr: got %0d expected 2", dut.rr_ptr);
      end
      n_checks++;
      if (iq_instr !== mk(43)) begin
         n_fail++;
         $display("FAIL mask0_payload_hold: got %h expected %h", iq_instr, mk(43));
      end
      instr   = mk(51);
      mask    = 4'b0100;
      iq_full = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready[%0d]: got %b expected 0", k, ready);
         end
         cyc();
         n_checks++;
         if (iq_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL full_strobe[%0d]: got %b expected 0000", k, iq_valid);
         end
      end
      iq_full = 4'b0000;
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drop_ready: got %b expected 1", ready);
      end
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0100) begin
         n_fail++;
         $display("FAIL full_drop_strobe: got %b expected 0100", iq_valid);
      end
      // Sparse mask: search from rr_ptr=3 picks EU3, then wraps to EU1.
      instr = mk(52);
      mask  = 4'b1010;
      cyc();
      n_checks++;
      if (iq_valid !== 4'b1000) begin
         n_fail++;
         $display("FAIL wrap_strobe0: got %b expected 1000", iq_valid);
      end
      instr = mk(53);
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0010) begin
         n_fail++;
         $display("FAIL wrap_strobe1: got %b expected 0010", iq_valid);
      end
      n_checks++;
      if (dut.rr_ptr !== 2'd2) begin
         n_fail++;
         $display("FAIL wrap_rr_ptr: got %0d expected 2", dut.rr_ptr);
      end
      valid  = 1'b0;
      mask   = 4'b0000;
      iq_pop = 4'b1110;
      cyc();
      iq_pop = 4'b0000;
   endtask

   task automatic test_reset_mid();
      instr = mk(60);
      mask  = 4'b1111;
      valid = 1'b1;
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0100) begin
         n_fail++;
         $display("FAIL midrst_pre_strobe: got %b expected 0100", iq_valid);
      end
      reset_n = 1'b0;
      valid   = 1'b0;
      mask    = 4'b0000;
      cyc();
      n_checks++;
      if (iq_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL midrst_strobe: got %b expected 0000", iq_valid);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut.cnt[i] !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_cnt[%0d]: got %0d expected 0", i, dut.cnt[i]);
         end
      end
      n_checks++;
      if (dut.rr_ptr !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_rr_ptr: got %0d expected 0", dut.rr_ptr);
      end
`ifdef EU_DISPATCH_STALL_CNT_EN
      n_checks++;
      if (stall !== 32'd0) begin
         n_fail++;
         $display("FAIL midrst_stall: got %0d expected 0", stall);
      end
`endif
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_stall();
      mask  = 4'b0001;
      valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         instr = mk(70 + k);
         cyc();
         n_checks++;
         if (iq_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_fill_strobe[%0d]: got %b expected 0001", k, iq_valid);
         end
      end
      instr = mk(74);
      for (int k = 0; k < 10; k++) begin
         #1;
         n_checks++;
         if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready[%0d]: got %b expected 0", k, ready);
         end
         cyc();
         n_checks++;
         if (iq_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_strobe[%0d]: got %b expected 0000", k, iq_valid);
         end
      end
`ifdef EU_DISPATCH_STALL_CNT_EN
      n_checks++;
      if (stall !== 32'd10) begin
         n_fail++;
         $display("FAIL stall_count: got %0d expected 10", stall);
      end
`endif
      valid = 1'b0;
      mask  = 4'b0000;
      cyc();
`ifdef EU_DISPATCH_STALL_CNT_EN
      n_checks++;
      if (stall !== 32'd10) begin
         n_fail++;
         $display("FAIL stall_count_hold: got %0d expected 10", stall);
      end
`endif
      n_checks++;
      if (dut.cnt[0] !== 3'd4) begin
         n_fail++;
         $display("FAIL stall_cnt: got %0d expected 4", dut.cnt[0]);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_credit_exhaustion();
      test_pop_grant();
      test_mask_handling();
      test_reset_mid();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
